// File: rtl/flex_counter_2d_if.sv
// Control and status bundle for flex_counter_2d: the master drives controls and limits,
// the slave (the counter) drives the coordinates and flags.
interface flex_counter_2d_if #(
    parameter int unsigned COL_BITS = 10,
    parameter int unsigned ROW_BITS = 10
);
    logic                clear;
    logic                load;
    logic [COL_BITS-1:0] load_col;
    logic [ROW_BITS-1:0] load_row;
    logic                count_enable;
    logic [COL_BITS-1:0] col_max;
    logic [ROW_BITS-1:0] row_max;
    logic [COL_BITS-1:0] col_count;
    logic [ROW_BITS-1:0] row_count;
    logic                col_last;
    logic                frame_last;
    logic                frame_done;
    logic                done;

    modport master (
        output clear, load, load_col, load_row, count_enable, col_max, row_max,
        input  col_count, row_count, col_last, frame_last, frame_done, done
    );

    modport slave (
        input  clear, load, load_col, load_row, count_enable, col_max, row_max,
        output col_count, row_count, col_last, frame_last, frame_done, done
    );
endinterface

// File: rtl/flex_counter_2d.sv
// Two-dimensional column/row scan counter with registered end-of-line, end-of-frame
// and frame-done flags, synchronous clear and coordinate load.
// Optional build macro FLEX_CNT2D_SATURATE_EN: stop at the end of the frame instead of
// wrapping, and raise a sticky done status until clear, load or reset.
module flex_counter_2d #(
    parameter int unsigned COL_BITS = 10,
    parameter int unsigned ROW_BITS = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    flex_counter_2d_if.slave  bus
);

    logic [COL_BITS-1:0] col_q, nxt_col;
    logic [ROW_BITS-1:0] row_q, nxt_row;
    logic                col_last_q, nxt_col_last;
    logic                frame_last_q, nxt_frame_last;
    logic                frame_done_q, nxt_frame_done;
    logic                col_wrap, row_wrap, step_ok;
`ifdef FLEX_CNT2D_SATURATE_EN
    logic                done_q, nxt_done;
`endif

    // Next coordinates and flags; >= lets a lowered limit wrap on the next step
    always_comb begin
        nxt_col        = col_q;
        nxt_row        = row_q;
        nxt_frame_done = 1'b0;
        col_wrap       = (col_q >= bus.col_max);
        row_wrap       = (row_q >= bus.row_max);
`ifdef FLEX_CNT2D_SATURATE_EN
        nxt_done       = done_q;
        step_ok        = bus.count_enable && !done_q;
`else
        step_ok        = bus.count_enable;
`endif
        if (bus.clear) begin
            nxt_col = '0;
            nxt_row = '0;
`ifdef FLEX_CNT2D_SATURATE_EN
            nxt_done = 1'b0;
`endif
        end else if (bus.load) begin
            nxt_col = bus.load_col;
            nxt_row = bus.load_row;
`ifdef FLEX_CNT2D_SATURATE_EN
            nxt_done = 1'b0;
`endif
        end else if (step_ok) begin
`ifdef FLEX_CNT2D_SATURATE_EN
            if (col_wrap && row_wrap) begin
                // End of frame: hold the coordinates and report completion once
                nxt_frame_done = 1'b1;
                nxt_done       = 1'b1;
            end else
`endif
            begin
                nxt_col = col_wrap ? '0 : col_q + COL_BITS'(1);
                if (col_wrap) begin
                    nxt_row = row_wrap ? '0 : row_q + ROW_BITS'(1);
                end
                nxt_frame_done = col_wrap && row_wrap;
            end
        end
        nxt_col_last   = (nxt_col == bus.col_max);
        nxt_frame_last = nxt_col_last && (nxt_row == bus.row_max);
    end

    // State and flag registers
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            col_q        <= '0;
            row_q        <= '0;
            col_last_q   <= 1'b0;
            frame_last_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= nxt_col;
            row_q        <= nxt_row;
            col_last_q   <= nxt_col_last;
            frame_last_q <= nxt_frame_last;
            frame_done_q <= nxt_frame_done;
        end
    end

`ifdef FLEX_CNT2D_SATURATE_EN
    // Sticky frame-complete status
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= nxt_done;
        end
    end
    assign bus.done = done_q;
`else
    assign bus.done = 1'b0;
`endif

    assign bus.col_count  = col_q;
    assign bus.row_count  = row_q;
    assign bus.col_last   = col_last_q;
    assign bus.frame_last = frame_last_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_flex_counter_2d.sv
// Directed bench for flex_counter_2d (default 10-bit widths).
module tb_flex_counter_2d;

    logic clk;
    logic n_rst;
    int   checks;
    int   errors;

    flex_counter_2d_if #(.COL_BITS(10), .ROW_BITS(10)) bus ();

    flex_counter_2d #(.COL_BITS(10), .ROW_BITS(10)) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear        = 1'b0;
        bus.load         = 1'b0;
        bus.count_enable = 1'b0;
        bus.load_col     = '0;
        bus.load_row     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.col_max = 10'd3;
        bus.row_max = 10'd2;
        n_rst = 1'b0;
        #12;
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done}
            !== {10'd0, 10'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset: got col=%0d row=%0d cl=%b fl=%b fd=%b done=%b, expected all 0",
                     bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_count();
        bus.col_max = 10'd3;
        bus.row_max = 10'd2;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.count_enable = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if ({bus.col_count, bus.row_count} !== {10'd1, 10'd1}) begin
            errors++;
            $display("FAIL reset_mid_pre: got col=%0d row=%0d, expected col=1 row=1",
                     bus.col_count, bus.row_count);
        end
        #2;
        n_rst = 1'b0;
        #1;
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done}
            !== {10'd0, 10'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_async: got col=%0d row=%0d cl=%b fl=%b fd=%b done=%b, expected all 0",
                     bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done);
        end
        tick();
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done}
            !== {10'd0, 10'd0, 4'b0000}) begin
            errors++;
            $display("FAIL reset_mid_held: got col=%0d row=%0d cl=%b fl=%b fd=%b done=%b, expected all 0",
                     bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done);
        end
        bus.count_enable = 1'b0;
        #2;
        n_rst = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        logic [9:0] ec, er;
        logic       ecl, efl, efd, ed;
        bus.col_max = 10'd3;
        bus.row_max = 10'd2;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.count_enable = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            ec  = 10'(k % 4);
            er  = 10'((k / 4) % 3);
            efd = (k == 12);
            ed  = 1'b0;
`ifdef FLEX_CNT2D_SATURATE_EN
            if (k == 12) begin
                ec = 10'd3;
                er = 10'd2;
                ed = 1'b1;
            end
`endif
            ecl = (ec == 10'd3);
            efl = ecl && (er == 10'd2);
            checks++;
            if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done}
                !== {ec, er, ecl, efl, efd, ed}) begin
                errors++;
                $display("FAIL full_frame step %0d: got col=%0d row=%0d cl=%b fl=%b fd=%b done=%b, expected col=%0d row=%0d cl=%b fl=%b fd=%b done=%b",
                         k, bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done,
                         ec, er, ecl, efl, efd, ed);
            end
        end
        bus.count_enable = 1'b0;
        tick();
        checks++;
        if ({bus.col_count, bus.frame_done} !== {ec, 1'b0}) begin
            errors++;
            $display("FAIL full_frame_hold: got col=%0d fd=%b, expected col=%0d fd=0",
                     bus.col_count, bus.frame_done, ec);
        end
    endtask

    task automatic test_priority();
        bus.col_max = 10'd3;
        bus.row_max = 10'd2;
        bus.load = 1'b1;
        bus.load_col = 10'd2;
        bus.load_row = 10'd1;
        tick();
        checks++;
        if ({bus.col_count, bus.row_count, bus.done} !== {10'd2, 10'd1, 1'b0}) begin
            errors++;
            $display("FAIL prio_load_start: got col=%0d row=%0d done=%b, expected col=2 row=1 done=0",
                     bus.col_count, bus.row_count, bus.done);
        end
        bus.clear = 1'b1;
        bus.count_enable = 1'b1;
        bus.load_col = 10'd5;
        bus.load_row = 10'd7;
        tick();
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_done} !== {10'd0, 10'd0, 2'b00}) begin
            errors++;
            $display("FAIL prio_clear: got col=%0d row=%0d cl=%b fd=%b, expected col=0 row=0 cl=0 fd=0",
                     bus.col_count, bus.row_count, bus.col_last, bus.frame_done);
        end
        bus.clear = 1'b0;
        tick();
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last} !== {10'd5, 10'd7, 2'b00}) begin
            errors++;
            $display("FAIL prio_load: got col=%0d row=%0d cl=%b fl=%b, expected col=5 row=7 cl=0 fl=0",
                     bus.col_count, bus.row_count, bus.col_last, bus.frame_last);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_limit_lowered();
        bus.col_max = 10'd9;
        bus.row_max = 10'd5;
        bus.load = 1'b1;
        bus.load_col = 10'd6;
        bus.load_row = 10'd0;
        tick();
        bus.load = 1'b0;
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last} !== {10'd6, 10'd0, 1'b0}) begin
            errors++;
            $display("FAIL lowered_pre: got col=%0d row=%0d cl=%b, expected col=6 row=0 cl=0",
                     bus.col_count, bus.row_count, bus.col_last);
        end
        bus.col_max = 10'd3;
        bus.count_enable = 1'b1;
        tick();
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_done} !== {10'd0, 10'd1, 2'b00}) begin
            errors++;
            $display("FAIL lowered_wrap: got col=%0d row=%0d cl=%b fd=%b, expected col=0 row=1 cl=0 fd=0",
                     bus.col_count, bus.row_count, bus.col_last, bus.frame_done);
        end
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last} !== {10'd3, 10'd1, 2'b10}) begin
            errors++;
            $display("FAIL lowered_last: got col=%0d row=%0d cl=%b fl=%b, expected col=3 row=1 cl=1 fl=0",
                     bus.col_count, bus.row_count, bus.col_last, bus.frame_last);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_degenerate();
        logic efd, ed;
        bus.col_max = 10'd0;
        bus.row_max = 10'd0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checks++;
        if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done} !== {10'd0, 10'd0, 3'b110}) begin
            errors++;
            $display("FAIL degen_clear: got col=%0d row=%0d cl=%b fl=%b fd=%b, expected col=0 row=0 cl=1 fl=1 fd=0",
                     bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done);
        end
        bus.count_enable = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
`ifdef FLEX_CNT2D_SATURATE_EN
            efd = (k == 1);
            ed  = 1'b1;
`else
            efd = 1'b1;
            ed  = 1'b0;
`endif
            checks++;
            if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done}
                !== {10'd0, 10'd0, 2'b11, efd, ed}) begin
                errors++;
                $display("FAIL degen step %0d: got col=%0d row=%0d cl=%b fl=%b fd=%b done=%b, expected col=0 row=0 cl=1 fl=1 fd=%b done=%b",
                         k, bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done, efd, ed);
            end
        end
        bus.count_enable = 1'b0;
        tick();
        checks++;
        if (bus.frame_done !== 1'b0) begin
            errors++;
            $display("FAIL degen_fd_clear: got fd=%b, expected fd=0", bus.frame_done);
        end
    endtask

`ifdef FLEX_CNT2D_SATURATE_EN
    task automatic test_saturate();
        logic [9:0] ec, er;
        logic       efd, ed;
        bus.col_max = 10'd1;
        bus.row_max = 10'd1;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.count_enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            case (k)
                1:       begin ec = 10'd1; er = 10'd0; end
                2:       begin ec = 10'd0; er = 10'd1; end
                default: begin ec = 10'd1; er = 10'd1; end
            endcase
            efd = (k == 4);
            ed  = (k >= 4);
            checks++;
            if ({bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done}
                !== {ec, er, (ec == 10'd1), (ec == 10'd1) && (er == 10'd1), efd, ed}) begin
                errors++;
                $display("FAIL saturate step %0d: got col=%0d row=%0d cl=%b fl=%b fd=%b done=%b, expected col=%0d row=%0d fd=%b done=%b",
                         k, bus.col_count, bus.row_count, bus.col_last, bus.frame_last, bus.frame_done, bus.done,
                         ec, er, efd, ed);
            end
        end
        bus.count_enable = 1'b0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        checks++;
        if ({bus.col_count, bus.row_count, bus.frame_done, bus.done} !== {10'd0, 10'd0, 2'b00}) begin
            errors++;
            $display("FAIL saturate_clear: got col=%0d row=%0d fd=%b done=%b, expected col=0 row=0 fd=0 done=0",
                     bus.col_count, bus.row_count, bus.frame_done, bus.done);
        end
    endtask
`else
    task automatic test_back_to_back();
        bus.col_max = 10'd1;
        bus.row_max = 10'd0;
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        bus.count_enable = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if ({bus.col_count, bus.row_count, bus.frame_done, bus.done}
                !== {10'(k % 2), 10'd0, (k % 2) == 0, 1'b0}) begin
                errors++;
                $display("FAIL back_to_back step %0d: got col=%0d row=%0d fd=%b done=%b, expected col=%0d row=0 fd=%b done=0",
                         k, bus.col_count, bus.row_count, bus.frame_done, bus.done, k % 2, (k % 2) == 0);
            end
        end
        idle_inputs();
        tick();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_reset_mid_count();
        test_full_frame();
        test_priority();
        test_limit_lowered();
        test_degenerate();
`ifdef FLEX_CNT2D_SATURATE_EN
        test_saturate();
`else
        test_back_to_back();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flex_counter_2d.md
# flex_counter_2d

Parametrised two-dimensional successor to the single-dimension flexible counter. Generates column/row scan coordinates for image traversal in the edge-detection datapath: the column counter advances on each enabled cycle, and the row counter advances when the column wraps. Provides registered end-of-line, end-of-frame and frame-done indications, a synchronous clear and a synchronous coordinate load.

## Interface
- COL_BITS, 10, width of column counter and column limit
- ROW_BITS, 10, width of row counter and row limit
- clk  in  1  rising-edge clock
- n_rst  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous clear of counters and flags; highest priority
- load  in  1  synchronous load of load_col/load_row; second priority
- load_col  in  COL_BITS  column value applied on load
- load_row  in  ROW_BITS  row value applied on load
- count_enable  in  1  advance one step this cycle; lowest priority
- col_max  in  COL_BITS  last column index, inclusive (line length = col_max+1)
- row_max  in  ROW_BITS  last row index, inclusive
- col_count  out  COL_BITS  current column, registered
- row_count  out  ROW_BITS  current row, registered
- col_last  out  1  registered; high while col_count == col_max
- frame_last  out  1  registered; high while col_last and row_count == row_max
- frame_done  out  1  registered one-cycle pulse on frame completion
- done  out  1  sticky frame-complete status (saturate build only)

## Operation
- Reset: col_count=0, row_count=0, col_last=0, frame_last=0, frame_done=0, done=0.
- Per-edge priority: clear > load > count_enable > hold.
- clear: counts←0, frame_done←0, done←0. Flags are recomputed from the new counts.
- load: col_count←load_col, row_count←row_load value load_row; frame_done←0, done←0. Out-of-range load values are accepted as given.
- Enabled step, column:
  - If col_count ≥ col_max, col←0 and the column wraps.
  - Otherwise col←col+1.
- Enabled step, row (only on a column wrap):
  - If row_count ≥ row_max, row←0 and the frame wraps.
  - Otherwise row←row+1.
- The ≥ comparison handles col_max or row_max lowered below the current count: the next step wraps rather than running to 2^N.
- col_max=0: the column wraps every step and the row advances every step.
- Both limits 0: every step is a frame wrap.
- frame_done is high for exactly one cycle following the edge at which a frame wrap occurs. Otherwise it is 0.
- Flags are computed every edge from the next count values and the current col_max/row_max:
  - col_last ← (nxt_col == col_max).
  - frame_last ← col_last_nxt && (nxt_row == row_max).
  - A limit change while idle is reflected on the flags one edge later.
- All arithmetic is unsigned at native width; there is no carry out.

## Timing
- Counters and flags update one clock after a qualifying input is sampled. Latency from enable to new count is one cycle.
- With count_enable held high, col_last is high in the same cycle col_count shows col_max.
- When the (col_max,row_max) → (0,0) transition is taken, frame_done is high in the same cycle the counts show (0,0).
- Back-to-back frames are supported with no dead cycle.
- A deasserted count_enable holds counts and flags. frame_done still clears to 0 after its single cycle.
- n_rst is asynchronous: it returns all outputs to reset values immediately, mid-frame included.

## Configuration
- FLEX_CNT2D_SATURATE_EN defined:
  - An enabled step at a frame-wrap point does not wrap. Counts hold at their current values.
  - frame_done pulses for one cycle and done←1.
  - While done=1, count_enable is ignored. Counts and flags hold, and frame_done stays 0.
  - done is cleared only by clear, load or reset.
- FLEX_CNT2D_SATURATE_EN undefined:
  - Free-running wrap as described in Operation.
  - done is tied to 0.

## Test plan
- Reset mid-count: col_max=3, row_max=2, enable for 5 cycles, pulse n_rst low between edges -> all outputs 0 immediately, held while low.
- Full frame wrap: col_max=3, row_max=2, enable 12 cycles:
  - Counts step (0,0)..(3,2) then back to (0,0).
  - col_last is high at col 3 of each row.
  - frame_last is high at (3,2).
  - frame_done is high for exactly one cycle, at (0,0).
- Priority: clear=1, load=1, enable=1 in the same cycle from (2,1) -> counts (0,0). Next cycle load=1, enable=1 with load_col=5, load_row=7 -> counts (5,7).
- Limit lowered: counts (6,0), col_max changed 9→3, one enabled step -> (0,1). col_last=0 before the step and 1 at the next col 3.
- Degenerate limits: col_max=0, row_max=0, enable 3 cycles -> counts stay (0,0), flags stay high, frame_done high on every cycle after the first step.
- Saturate build: col_max=1, row_max=1, enable 6 cycles:
  - Counts reach (1,1) and hold.
  - frame_done pulses once, done=1.
  - Subsequent enables leave the state unchanged.
  - clear -> done=0, counts (0,0).
